word_serializer: RTL and testbench

Parallel-to-serial front end for the bit-stream pattern detectors in the lab datapath. It accepts WIDTH-bit words over a valid/ready handshake and emits them one bit per clock on a single serial line. Its output drives the detector's `in` pin directly. A one-word holding register lets consecutive words stream with no idle cycle between them, so patterns spanning a word boundary are still detected.

---
 rtl/word_serializer_pkg.sv | 13 +
 rtl/word_serializer_if.sv | 37 +++
 rtl/word_serializer.sv | 104 ++++++++++
 tb/tb_word_serializer.sv | 238 +++++++++++++++++++++++
 4 files changed

// File: rtl/word_serializer_pkg.sv
// Shared types and defaults for the word serializer.
// The FSM state encoding and parameter defaults live here.
package word_serializer_pkg;

    typedef enum logic {
        IDLE,
        SHIFT
    } state_t;

    localparam int   DEFAULT_WIDTH    = 8;
    localparam logic DEFAULT_IDLE_BIT = 1'b0;

endpackage

// File: rtl/word_serializer_if.sv
// Parallel word input handshake plus serial output bundle of the word serializer.
// The slave modport is the serializer side; the master modport is the producer/consumer side.
interface word_serializer_if
    import word_serializer_pkg::*;
#(
    parameter int WIDTH = DEFAULT_WIDTH
) ();

    logic [WIDTH-1:0] din;
    logic             din_valid;
    logic             din_ready;
    logic             ser_out;
    logic             ser_valid;
    logic             last;
    logic             busy;

    modport slave (
        input  din,
        input  din_valid,
        output din_ready,
        output ser_out,
        output ser_valid,
        output last,
        output busy
    );

    modport master (
        output din,
        output din_valid,
        input  din_ready,
        input  ser_out,
        input  ser_valid,
        input  last,
        input  busy
    );

endinterface

// File: rtl/word_serializer.sv
// Parallel-to-serial converter with a one-word holding register, so consecutive
// words leave on ser_out with no idle cycle between them.
module word_serializer
    import word_serializer_pkg::*;
#(
    parameter int   WIDTH     = DEFAULT_WIDTH,
    parameter bit   MSB_FIRST = 1'b1,
    parameter logic IDLE_BIT  = DEFAULT_IDLE_BIT
) (
    input  logic             clk,
    input  logic             reset,
    word_serializer_if.slave bus
);

    localparam int            CW      = $clog2(WIDTH);
    localparam logic [CW-1:0] CNT_TOP = CW'(WIDTH - 1);

    state_t           state_reg, state_next;
    logic [WIDTH-1:0] sr_reg, sr_next;
    logic [WIDTH-1:0] hr_reg, hr_next;
    logic [CW-1:0]    cnt_reg, cnt_next;
    logic             hf_reg, hf_next;
    logic             ser_out_reg, ser_out_next;
    logic             ser_valid_reg, ser_valid_next;

    logic             last;
    logic             shifter_free;
    logic             transfer;
    logic [WIDTH-1:0] load_word;
    logic [WIDTH-1:0] shifted;

    function automatic logic first_bit(input logic [WIDTH-1:0] w);
        return MSB_FIRST ? w[WIDTH-1] : w[0];
    endfunction

    assign last         = ser_valid_reg && (cnt_reg == '0);
    assign shifter_free = (state_reg == IDLE) || last;
    // din_ready depends only on hf_reg, so the transfer has no comb path back to din_valid.
    assign transfer     = bus.din_valid && !hf_reg;
    // A held word always wins over a new bypass word when the shifter frees up.
    assign load_word    = hf_reg ? hr_reg : bus.din;
    assign shifted      = MSB_FIRST ? {sr_reg[WIDTH-2:0], 1'b0} : {1'b0, sr_reg[WIDTH-1:1]};

    always_comb begin
        state_next     = state_reg;
        sr_next        = sr_reg;
        hr_next        = hr_reg;
        hf_next        = hf_reg;
        cnt_next       = cnt_reg;
        ser_out_next   = ser_out_reg;
        ser_valid_next = ser_valid_reg;

        if (shifter_free) begin
            if (hf_reg || transfer) begin
                state_next     = SHIFT;
                sr_next        = load_word;
                hf_next        = 1'b0;
                cnt_next       = CNT_TOP;
                ser_out_next   = first_bit(load_word);
                ser_valid_next = 1'b1;
            end else begin
                state_next     = IDLE;
                cnt_next       = '0;
                ser_out_next   = IDLE_BIT;
                ser_valid_next = 1'b0;
            end
        end else begin
            sr_next      = shifted;
            ser_out_next = first_bit(shifted);
            cnt_next     = cnt_reg - 1'b1;
            if (transfer) begin
                hr_next = bus.din;
                hf_next = 1'b1;
            end
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_reg     <= IDLE;
            sr_reg        <= '0;
            hr_reg        <= '0;
            hf_reg        <= 1'b0;
            cnt_reg       <= '0;
            ser_out_reg   <= IDLE_BIT;
            ser_valid_reg <= 1'b0;
        end else begin
            state_reg     <= state_next;
            sr_reg        <= sr_next;
            hr_reg        <= hr_next;
            hf_reg        <= hf_next;
            cnt_reg       <= cnt_next;
            ser_out_reg   <= ser_out_next;
            ser_valid_reg <= ser_valid_next;
        end
    end

    assign bus.din_ready = !hf_reg;
    assign bus.ser_out   = ser_out_reg;
    assign bus.ser_valid = ser_valid_reg;
    assign bus.last      = last;
    assign bus.busy      = (state_reg == SHIFT) || hf_reg;

endmodule

// File: tb/tb_word_serializer.sv
// Bench for word_serializer: MSB-first and LSB-first instances share one stimulus
// stream and are compared each cycle against a word-queue reference model.
module tb_word_serializer;
    import word_serializer_pkg::*;

    localparam int   W    = 8;
    localparam logic IDLE = 1'b0;

    logic         clk = 1'b0;
    logic         reset;
    logic [W-1:0] din;
    logic         din_valid;

    always #5 clk = ~clk;

    word_serializer_if #(.WIDTH(W)) m_if ();
    word_serializer_if #(.WIDTH(W)) l_if ();

    assign m_if.din       = din;
    assign m_if.din_valid = din_valid;
    assign l_if.din       = din;
    assign l_if.din_valid = din_valid;

    word_serializer #(.WIDTH(W), .MSB_FIRST(1'b1), .IDLE_BIT(IDLE)) dut_m (
        .clk   (clk),
        .reset (reset),
        .bus   (m_if)
    );

    word_serializer #(.WIDTH(W), .MSB_FIRST(1'b0), .IDLE_BIT(IDLE)) dut_l (
        .clk   (clk),
        .reset (reset),
        .bus   (l_if)
    );

    int n_checks = 0;
    int n_fail   = 0;
    int cyc      = 0;

    // Reference model: words accepted and not yet fully sent (front = on the wire).
    logic [W-1:0] q[$];
    int           bit_idx     = -1;
    bit           last_accept = 1'b0;

    // Captured serial stream (valid bits only) and a 1010 detector on it.
    logic [31:0] cap_m, cap_l;
    int          cap_n;
    logic [3:0]  det_win;
    int          det_cnt;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic model_reset();
        q.delete();
        bit_idx     = -1;
        last_accept = 1'b0;
    endtask

    // Capacity is two words (one on the wire, one waiting); a word finishes after W bits.
    task automatic model_edge();
        bit acc;
        bit free;
        acc         = din_valid && (q.size() < 2);
        free        = (bit_idx < 0) || (bit_idx == W - 1);
        last_accept = acc;
        if (free) begin
            if (bit_idx >= 0) void'(q.pop_front());
            if (acc) q.push_back(din);
            bit_idx = (q.size() > 0) ? 0 : -1;
        end else begin
            bit_idx++;
            if (acc) q.push_back(din);
        end
    endtask

    function automatic logic exp_bit(input bit msb);
        int i;
        if (bit_idx < 0) return IDLE;
        i = msb ? (W - 1 - bit_idx) : bit_idx;
        return q[0][i];
    endfunction

    task automatic check_dut(input string n, input logic so, input logic sv, input logic la,
                             input logic rdy, input logic bz, input bit msb);
        check($sformatf("%s.ser_out@%0d", n, cyc), so, exp_bit(msb));
        check($sformatf("%s.ser_valid@%0d", n, cyc), sv, bit_idx >= 0);
        check($sformatf("%s.last@%0d", n, cyc), la, bit_idx == W - 1);
        check($sformatf("%s.din_ready@%0d", n, cyc), rdy, q.size() < 2);
        check($sformatf("%s.busy@%0d", n, cyc), bz, q.size() > 0);
    endtask

    task automatic check_all();
        check_dut("m", m_if.ser_out, m_if.ser_valid, m_if.last, m_if.din_ready, m_if.busy, 1'b1);
        check_dut("l", l_if.ser_out, l_if.ser_valid, l_if.last, l_if.din_ready, l_if.busy, 1'b0);
        if (m_if.ser_valid) begin
            cap_m   = {cap_m[30:0], m_if.ser_out};
            cap_n++;
            det_win = {det_win[2:0], m_if.ser_out};
            if (cap_n >= 4 && det_win == 4'b1010) det_cnt++;
        end
        if (l_if.ser_valid) cap_l = {cap_l[30:0], l_if.ser_out};
    endtask

    task automatic cap_reset();
        cap_m   = '0;
        cap_l   = '0;
        cap_n   = 0;
        det_win = '0;
        det_cnt = 0;
    endtask

    task automatic step();
        @(posedge clk);
        if (!reset) model_edge();
        @(negedge clk);
        cyc++;
        check_all();
    endtask

    task automatic idle(input int n);
        din_valid = 1'b0;
        repeat (n) step();
    endtask

    task automatic send_word(input logic [W-1:0] w);
        int n;
        n         = 0;
        din       = w;
        din_valid = 1'b1;
        do begin
            step();
            n++;
        end while (!last_accept && n < 4 * W);
        check($sformatf("accept_bound@%0d", cyc), last_accept, 1'b1);
        din_valid = 1'b0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        reset     = 1'b1;
        din       = '0;
        din_valid = 1'b0;
        model_reset();
        cap_reset();
        #2;
        check_all();
        @(negedge clk);
        reset = 1'b0;

        // Single word, MSB first
        idle(2);
        cap_reset();
        send_word(8'hA5);
        idle(W + 1);
        check("a5_bits_m", cap_m[7:0], 8'hA5);
        check("a5_bits_l", cap_l[7:0], 8'hA5);
        check("a5_count", cap_n, 8);

        // Back-to-back streaming
        cap_reset();
        send_word(8'h0A);
        send_word(8'h0A);
        check("ready_drop", m_if.din_ready, 1'b0);
        idle(2 * W + 1);
        check("stream_bits", cap_m[15:0], 16'h0A0A);
        check("stream_count", cap_n, 16);
        check("stream_1010", det_cnt, 2);

        // Backpressure with three words
        cap_reset();
        send_word(8'h11);
        send_word(8'h22);
        send_word(8'h33);
        idle(3 * W);
        check("bp_bits", cap_m[23:0], 24'h112233);
        check("bp_count", cap_n, 24);

        // Bit order
        cap_reset();
        send_word(8'h01);
        idle(W + 1);
        check("lsb_m", cap_m[7:0], 8'h01);
        check("lsb_l", cap_l[7:0], 8'h80);

        // Reset in the middle of a word with a word held
        send_word(8'hFF);
        send_word(8'h00);
        step();
        #2;
        reset = 1'b1;
        model_reset();
        #1;
        check_all();
        check("rst_busy", m_if.busy, 1'b0);
        @(posedge clk);
        @(negedge clk);
        check_all();
        reset = 1'b0;
        cap_reset();
        send_word(8'h80);
        idle(W + 1);
        check("post_rst_bits", cap_m[7:0], 8'h80);
        check("post_rst_count", cap_n, 8);

        // Idle gap between words
        send_word(8'h3C);
        idle(W + 5);
        send_word(8'hC3);
        check("gap_first_valid", m_if.ser_valid, 1'b1);
        check("gap_first_bit", m_if.ser_out, 1'b1);
        idle(W + 1);

        // Randomized traffic, holding din stable while stalled
        for (int c = 0; c < 1500; c++) begin
            if (!(din_valid && !last_accept)) begin
                din_valid = ($urandom_range(0, 3) != 0);
                din       = W'($urandom);
            end
            step();
        end
        idle(3 * W);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
